// File: rtl/seq_detect_prog.sv
// Programmable Moore sequence detector: matches a runtime-loaded serial pattern
// of 1..MAX_LEN bits, with overlap control, valid qualification and a saturating count.
module seq_detect_prog #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               count_clr,
   input  logic               in_valid,
   input  logic               a,
   output logic               b,
   output logic [CNT_W-1:0]   match_count
);

   typedef enum logic [1:0] {IDLE, SEARCH, MATCH} state_t;

   state_t             state, state_next;
   logic [MAX_LEN-1:0] pat;
   logic [LEN_W-1:0]   len_q;
   logic               ovl;
   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   fill;

   logic [LEN_W-1:0]   len_clamped;
   logic [MAX_LEN-1:0] len_mask;
   logic [MAX_LEN-1:0] hist_next;
   logic [LEN_W:0]     fill_inc;
   logic               accept;
   logic               match_cond;
   logic               enter_match;

   // Datapath decode: clamp, length mask, shifted history and match test
   always_comb begin
      len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      len_mask    = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(len_q)) len_mask[i] = 1'b1;
      end
      hist_next   = (hist << 1) | MAX_LEN'(a);
      fill_inc    = {1'b0, fill} + 1'b1;
      accept      = in_valid && !cfg_load;
      match_cond  = (state != IDLE) &&
                    (fill_inc >= {1'b0, len_q}) &&
                    ((hist_next & len_mask) == (pat & len_mask));
      enter_match = accept && match_cond;
   end

   always_comb begin
      state_next = state;
      if (cfg_load) begin
         state_next = (len_clamped == '0) ? IDLE : SEARCH;
      end else begin
         case (state)
            IDLE:    state_next = IDLE;
            SEARCH,
            MATCH:   begin
               if (accept) state_next = match_cond ? MATCH : SEARCH;
               else        state_next = SEARCH;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Config, history and fill; a non-overlapping match restarts the fill count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat   <= '0;
         len_q <= '0;
         ovl   <= 1'b0;
         hist  <= '0;
         fill  <= '0;
      end else if (cfg_load) begin
         pat   <= cfg_pattern;
         len_q <= len_clamped;
         ovl   <= cfg_overlap;
         hist  <= '0;
         fill  <= '0;
      end else if (accept) begin
         hist <= hist_next;
         if (match_cond && !ovl)
            fill <= '0;
         else if (fill_inc > (LEN_W+1)'(MAX_LEN))
            fill <= LEN_W'(MAX_LEN);
         else
            fill <= fill_inc[LEN_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_count <= '0;
      end else if (count_clr) begin
         match_count <= enter_match ? CNT_W'(1) : '0;
      end else if (enter_match && (match_count != {CNT_W{1'b1}})) begin
         match_count <= match_count + 1'b1;
      end
   end

   assign b = (state == MATCH);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: a default instance plus a 2-bit counter
// instance sharing the same stimulus for the saturation scenario.
module tb_seq_detect_prog;

   logic       clk;
   logic       rst;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       count_clr;
   logic       in_valid;
   logic       a;
   logic       b;
   logic [7:0] match_count;
   logic       b_sat;
   logic [1:0] match_count_sat;

   int n_checks = 0;
   int n_fail   = 0;

   seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .count_clr(count_clr),
      .in_valid(in_valid), .a(a), .b(b), .match_count(match_count)
   );

   seq_detect_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .count_clr(count_clr),
      .in_valid(in_valid), .a(a), .b(b_sat), .match_count(match_count_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
      cfg_load    = 1'b1;
      count_clr   = 1'b1;
      @(posedge clk); #1;
      cfg_load    = 1'b0;
      count_clr   = 1'b0;
   endtask

   task automatic send_bit(input logic v);
      in_valid = 1'b1;
      a        = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [3:0] bits;
      bits = 4'b1011;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid    = i[0];
         a           = ~i[0];
         cfg_load    = i[1];
         cfg_pattern = 8'b0000_1011;
         cfg_len     = 4'd4;
         @(posedge clk); #1;
         if (b !== 1'b0 || match_count !== 8'd0) begin
            $display("[TB] FAIL reset_hold cyc%0d: b=%b count=%0d, required b=0 count=0", i, b, match_count);
            n_fail++;
         end
         n_checks++;
      end
      cfg_load = 1'b0;
      in_valid = 1'b0;
      rst      = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         send_bit(bits[i]);
         if (b !== 1'b0) begin
            $display("[TB] FAIL reset_noload bit%0d: b=%b, required 0", 3 - i, b);
            n_fail++;
         end
         n_checks++;
      end
      if (match_count !== 8'd0) begin
         $display("[TB] FAIL reset_noload_count: got %0d, required 0", match_count);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_overlap();
      logic [6:0] bits;
      logic [6:0] exp_b;
      bits  = 7'b1011011;
      exp_b = 7'b0001001;
      load_cfg(8'b0000_1011, 4'd4, 1'b1);
      for (int i = 6; i >= 0; i--) begin
         send_bit(bits[i]);
         if (b !== exp_b[i]) begin
            $display("[TB] FAIL overlap_b bit%0d: got %b, required %b", 6 - i, b, exp_b[i]);
            n_fail++;
         end
         n_checks++;
      end
      if (match_count !== 8'd2) begin
         $display("[TB] FAIL overlap_count: got %0d, required 2", match_count);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_non_overlap();
      logic [6:0] bits;
      logic [6:0] exp_b;
      bits  = 7'b1011011;
      exp_b = 7'b0001000;
      load_cfg(8'b0000_1011, 4'd4, 1'b0);
      for (int i = 6; i >= 0; i--) begin
         send_bit(bits[i]);
         if (b !== exp_b[i]) begin
            $display("[TB] FAIL nonoverlap_b bit%0d: got %b, required %b", 6 - i, b, exp_b[i]);
            n_fail++;
         end
         n_checks++;
      end
      if (match_count !== 8'd1) begin
         $display("[TB] FAIL nonoverlap_count: got %0d, required 1", match_count);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_valid_gaps();
      logic [2:0] bits;
      logic [2:0] exp_b;
      bits  = 3'b101;
      exp_b = 3'b001;
      load_cfg(8'b0000_0101, 4'd3, 1'b0);
      for (int i = 2; i >= 0; i--) begin
         send_bit(bits[i]);
         if (b !== exp_b[i]) begin
            $display("[TB] FAIL gaps_b bit%0d: got %b, required %b", 2 - i, b, exp_b[i]);
            n_fail++;
         end
         n_checks++;
         for (int g = 0; g < 2; g++) begin
            idle_cycle();
            if (b !== 1'b0) begin
               $display("[TB] FAIL gaps_idle bit%0d gap%0d: got %b, required 0", 2 - i, g, b);
               n_fail++;
            end
            n_checks++;
         end
      end
      if (match_count !== 8'd1) begin
         $display("[TB] FAIL gaps_count: got %0d, required 1", match_count);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_saturation();
      logic [1:0] exp_sat;
      load_cfg(8'b0000_0001, 4'd1, 1'b1);
      for (int i = 1; i <= 6; i++) begin
         send_bit(1'b1);
         exp_sat = (i >= 3) ? 2'd3 : 2'(i);
         if (b !== 1'b1 || b_sat !== 1'b1) begin
            $display("[TB] FAIL sat_b bit%0d: b=%b b_sat=%b, required 1", i, b, b_sat);
            n_fail++;
         end
         n_checks++;
         if (match_count_sat !== exp_sat || match_count !== 8'(i)) begin
            $display("[TB] FAIL sat_count bit%0d: sat=%0d wide=%0d, required sat=%0d wide=%0d",
                     i, match_count_sat, match_count, exp_sat, i);
            n_fail++;
         end
         n_checks++;
      end
      count_clr = 1'b1;
      send_bit(1'b1);
      count_clr = 1'b0;
      if (match_count_sat !== 2'd1 || match_count !== 8'd1) begin
         $display("[TB] FAIL clr_with_match: sat=%0d wide=%0d, required 1", match_count_sat, match_count);
         n_fail++;
      end
      n_checks++;
      count_clr = 1'b1;
      idle_cycle();
      count_clr = 1'b0;
      if (match_count_sat !== 2'd0 || match_count !== 8'd0 || b !== 1'b0) begin
         $display("[TB] FAIL clr_alone: sat=%0d wide=%0d b=%b, required 0 0 0", match_count_sat, match_count, b);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_len_clamp();
      logic [7:0] bits;
      logic [7:0] exp_b;
      bits  = 8'b1011_0011;
      exp_b = 8'b0000_0001;
      load_cfg(8'b1011_0011, 4'd12, 1'b0);
      for (int i = 7; i >= 0; i--) begin
         send_bit(bits[i]);
         if (b !== exp_b[i]) begin
            $display("[TB] FAIL clamp_b bit%0d: got %b, required %b", 7 - i, b, exp_b[i]);
            n_fail++;
         end
         n_checks++;
      end
      if (match_count !== 8'd1) begin
         $display("[TB] FAIL clamp_count: got %0d, required 1", match_count);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_len_zero();
      load_cfg(8'b0000_0001, 4'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send_bit(1'b1);
         if (b !== 1'b0) begin
            $display("[TB] FAIL lenzero_b bit%0d: got %b, required 0", i, b);
            n_fail++;
         end
         n_checks++;
      end
      if (match_count !== 8'd0) begin
         $display("[TB] FAIL lenzero_count: got %0d, required 0", match_count);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_load_mid_pattern();
      logic [4:0] bits;
      logic [4:0] exp_b;
      bits  = 5'b11011;
      exp_b = 5'b00001;
      load_cfg(8'b0000_1011, 4'd4, 1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      cfg_load = 1'b1;
      in_valid = 1'b1;
      a        = 1'b1;
      @(posedge clk); #1;
      cfg_load = 1'b0;
      in_valid = 1'b0;
      a        = 1'b0;
      if (b !== 1'b0) begin
         $display("[TB] FAIL reload_b: got %b, required 0", b);
         n_fail++;
      end
      n_checks++;
      for (int i = 4; i >= 0; i--) begin
         send_bit(bits[i]);
         if (b !== exp_b[i]) begin
            $display("[TB] FAIL reload_seq bit%0d: got %b, required %b", 4 - i, b, exp_b[i]);
            n_fail++;
         end
         n_checks++;
      end
   endtask

   task automatic test_mid_reset();
      logic [3:0] bits;
      bits = 4'b1011;
      load_cfg(8'b0000_1011, 4'd4, 1'b1);
      for (int i = 3; i >= 0; i--) send_bit(bits[i]);
      if (b !== 1'b1) begin
         $display("[TB] FAIL midreset_pre: b=%b, required 1", b);
         n_fail++;
      end
      n_checks++;
      #2 rst = 1'b0;
      #1;
      if (b !== 1'b0 || match_count !== 8'd0) begin
         $display("[TB] FAIL midreset_async: b=%b count=%0d, required 0 0", b, match_count);
         n_fail++;
      end
      n_checks++;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         send_bit(bits[i]);
         if (b !== 1'b0) begin
            $display("[TB] FAIL midreset_cfgcleared bit%0d: b=%b, required 0", 3 - i, b);
            n_fail++;
         end
         n_checks++;
      end
   endtask

   initial begin
      rst         = 1'b0;
      cfg_load    = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      count_clr   = 1'b0;
      in_valid    = 1'b0;
      a           = 1'b0;
      #1;
      test_reset();
      test_overlap();
      test_non_overlap();
      test_valid_gaps();
      test_saturation();
      test_len_clamp();
      test_len_zero();
      test_load_mid_pattern();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
